// File: rtl/pc_gen_ras.sv
// pc_gen_ras: program-counter generator for the MIPS fetch stage.
//   Replaces the plain PC register with stall, branch/jump redirect,
//   trap entry/return with a saved EPC, and a circular return-address stack.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall             hold PC, RAS and mode (overridden by trap)
//   trap, eret        exception entry / return from exception
//   br_taken/target   conditional branch redirect
//   jump, call, ret   jump (call pushes return address), return pops RAS
//   jump_target       jump destination, also fallback target for ret on empty RAS
//   pc, pc_plus       current PC and pc + INC
//   epc, in_trap      saved exception PC, trap-handler mode
//   ras_count         valid RAS entries
//   ras_ovf           sticky: push while full
//   ras_unf           one-cycle pulse: ret with empty RAS
//   dbl_fault         one-cycle pulse: trap while already in trap mode
module pc_gen_ras #(
  parameter int unsigned    XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h80,
  parameter int unsigned    INC       = 4,
  parameter int unsigned    RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         trap,
  input  logic                         eret,
  input  logic                         br_taken,
  input  logic [XLEN-1:0]              br_target,
  input  logic                         jump,
  input  logic                         call,
  input  logic                         ret,
  input  logic [XLEN-1:0]              jump_target,
  output logic [XLEN-1:0]              pc,
  output logic [XLEN-1:0]              pc_plus,
  output logic [XLEN-1:0]              epc,
  output logic                         in_trap,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf,
  output logic                         dbl_fault
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {NORMAL, TRAP} mode_e;

  mode_e            mode_q, mode_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             dbl_q, dbl_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic             push;
  logic [PTR_W-1:0] top_idx;
  logic [XLEN-1:0]  pc_inc;

  assign pc_inc  = pc_q + XLEN'(INC);
  assign top_idx = ptr_q - 1'b1;

  always_comb begin
    mode_d = mode_q;
    pc_d   = pc_inc;
    epc_d  = epc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = 1'b0;
    dbl_d  = 1'b0;
    push   = 1'b0;

    if (trap) begin
      pc_d   = TRAP_VEC;
      mode_d = TRAP;
      if (mode_q == TRAP) dbl_d = 1'b1;
      else                epc_d = pc_q;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (eret && mode_q == TRAP) begin
      pc_d   = epc_q;
      mode_d = NORMAL;
    end else if (br_taken) begin
      pc_d = br_target;
    end else if (ret) begin
      if (cnt_q != '0) begin
        pc_d  = ras_q[top_idx];
        ptr_d = top_idx;
        cnt_d = cnt_q - 1'b1;
      end else begin
        pc_d  = jump_target;
        unf_d = 1'b1;
      end
    end else if (jump) begin
      pc_d = jump_target;
      if (call) begin
        // Writing at ptr when full lands on the oldest entry, so the
        // circular overwrite falls out of the normal push path.
        push  = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
        else                            cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= NORMAL;
      pc_q   <= RESET_VEC;
      epc_q  <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      dbl_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      dbl_q  <= dbl_d;
    end
  end

  // Entry contents need no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (!rst && push) ras_q[ptr_q] <= pc_inc;
  end

  assign pc        = pc_q;
  assign pc_plus   = pc_inc;
  assign epc       = epc_q;
  assign in_trap   = (mode_q == TRAP);
  assign ras_count = cnt_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
  assign dbl_fault = dbl_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
module tb_pc_gen_ras;

  logic        clk = 1'b0;
  logic        rst, stall, trap, eret, br_taken, jump, call, ret;
  logic [31:0] br_target, jump_target;
  logic [31:0] pc, pc_plus, epc;
  logic        in_trap, ras_ovf, ras_unf, dbl_fault;
  logic [2:0]  ras_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  pc_gen_ras #(
    .XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h80), .INC(4), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .trap(trap), .eret(eret),
    .br_taken(br_taken), .br_target(br_target), .jump(jump), .call(call),
    .ret(ret), .jump_target(jump_target), .pc(pc), .pc_plus(pc_plus),
    .epc(epc), .in_trap(in_trap), .ras_count(ras_count), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf), .dbl_fault(dbl_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; stall = 0; trap = 0; eret = 0; br_taken = 0; jump = 0; call = 0; ret = 0;
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input logic [31:0] tgt);
    idle(); jump = 1; call = 1; jump_target = tgt;
    step();
  endtask

  task automatic do_ret(input logic [31:0] fallback);
    idle(); ret = 1; jump_target = fallback;
    step();
  endtask

  initial begin
    idle(); br_target = '0; jump_target = '0;

    // 1. reset and sequential fetch
    rst = 1; step();
    check("rst_pc", pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_cnt", {29'b0, ras_count}, 32'd0);
    check("rst_flags", {28'b0, in_trap, ras_ovf, ras_unf, dbl_fault}, 32'h0);
    idle();
    step(); check("seq_pc1", pc, 32'h4);
    step(); check("seq_pc2", pc, 32'h8);
    step(); check("seq_pc3", pc, 32'hC);
    check("seq_pcplus", pc_plus, 32'h10);
    step(); check("seq_pc4", pc, 32'h10);

    // 2. stall drops a concurrent branch
    stall = 1; br_taken = 1; br_target = 32'h40;
    step(); check("stall_1", pc, 32'h10);
    step(); check("stall_2", pc, 32'h10);
    idle();
    step(); check("stall_rel", pc, 32'h14);

    // 3. single call/ret
    step(); step(); step(); check("pre_call", pc, 32'h20);
    do_call(32'h100);
    check("call_pc", pc, 32'h100);
    check("call_cnt", {29'b0, ras_count}, 32'd1);
    do_ret(32'h0);
    check("ret_pc", pc, 32'h24);
    check("ret_cnt", {29'b0, ras_count}, 32'd0);

    // 4. overflow then underflow
    do_call(32'h300); do_call(32'h400); do_call(32'h500); do_call(32'h600);
    check("full_cnt", {29'b0, ras_count}, 32'd4);
    check("full_noovf", {31'b0, ras_ovf}, 32'd0);
    do_call(32'h700);
    check("ovf_pc", pc, 32'h700);
    check("ovf_cnt", {29'b0, ras_count}, 32'd4);
    check("ovf_flag", {31'b0, ras_ovf}, 32'd1);
    do_ret(32'h0); check("pop1", pc, 32'h604);
    do_ret(32'h0); check("pop2", pc, 32'h504);
    do_ret(32'h0); check("pop3", pc, 32'h404);
    do_ret(32'h0); check("pop4", pc, 32'h304);
    check("pop4_cnt", {29'b0, ras_count}, 32'd0);
    check("pop4_nounf", {31'b0, ras_unf}, 32'd0);
    do_ret(32'h200);
    check("unf_pc", pc, 32'h200);
    check("unf_pulse", {31'b0, ras_unf}, 32'd1);
    idle(); step();
    check("unf_clear", {31'b0, ras_unf}, 32'd0);
    check("ovf_sticky", {31'b0, ras_ovf}, 32'd1);
    check("after_unf", pc, 32'h204);

    // 5. trap, double fault, eret
    br_taken = 1; br_target = 32'h30; step();
    check("to_30", pc, 32'h30);
    idle(); trap = 1; stall = 1; step();
    check("trap_pc", pc, 32'h80);
    check("trap_epc", epc, 32'h30);
    check("trap_mode", {31'b0, in_trap}, 32'd1);
    check("trap_nodbl", {31'b0, dbl_fault}, 32'd0);
    idle(); trap = 1; step();
    check("dbl_pc", pc, 32'h80);
    check("dbl_epc", epc, 32'h30);
    check("dbl_pulse", {31'b0, dbl_fault}, 32'd1);
    idle(); step();
    check("dbl_clear", {31'b0, dbl_fault}, 32'd0);
    check("handler_pc", pc, 32'h84);
    eret = 1; step();
    check("eret_pc", pc, 32'h30);
    check("eret_mode", {31'b0, in_trap}, 32'd0);
    eret = 1; step();
    check("eret_normal", pc, 32'h34);

    // 6. trap beats branch and ret; rst mid call-sequence
    do_call(32'h100);
    check("c6_cnt", {29'b0, ras_count}, 32'd1);
    idle(); trap = 1; br_taken = 1; br_target = 32'h40; ret = 1; step();
    check("prio_pc", pc, 32'h80);
    check("prio_cnt", {29'b0, ras_count}, 32'd1);
    check("prio_epc", epc, 32'h100);
    idle(); rst = 1; jump = 1; call = 1; jump_target = 32'h500; step();
    check("rst2_pc", pc, 32'h0);
    check("rst2_cnt", {29'b0, ras_count}, 32'd0);
    check("rst2_epc", epc, 32'h0);
    check("rst2_flags", {28'b0, in_trap, ras_ovf, ras_unf, dbl_fault}, 32'h0);
    do_call(32'h100);
    do_ret(32'h0);
    check("post_rst_ret", pc, 32'h4);

    // pc_plus wraps at all-ones
    idle(); br_taken = 1; br_target = 32'hFFFF_FFFC; step();
    check("wrap_plus", pc_plus, 32'h0);
    idle(); step();
    check("wrap_pc", pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
